// File: rtl/btn_debounce.sv
// btn_debounce: per-channel synchronizer, debounce FSM and optional hold-to-repeat
// for push buttons, all paced by an external 1 ms tick strobe.
module btn_debounce #(
    parameter int               N_BTN         = 4,
    parameter int               DB_MS         = 20,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = '0,
    parameter int               REPEAT_DLY_MS = 500,
    parameter int               REPEAT_MS     = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1ms,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);
    typedef enum logic [1:0] {IDLE, ARM_DN, DOWN, ARM_UP} state_t;

    logic [N_BTN-1:0] meta_q, sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= btn_in;
            sync_q <= meta_q;
        end
    end

    genvar g;
    for (g = 0; g < N_BTN; g++) begin : g_ch
        state_t      state_q;
        logic [7:0]  cnt_q;
        logic [11:0] rpt_q, rpt_inc;
        logic        level_q, press_q, release_q;
        logic        s, db_done, held, rpt_hit, rpt_fire;

        assign s        = sync_q[g];
        assign db_done  = tick_1ms && cnt_q == 8'(DB_MS - 1);
        assign held     = state_q == DOWN || state_q == ARM_UP;
        assign rpt_inc  = rpt_q + 12'd1;
        assign rpt_hit  = REPEAT_MASK[g] && tick_1ms && held && rpt_inc == 12'(REPEAT_DLY_MS);
        // a repeat landing on the same tick as the accepted release is dropped
        assign rpt_fire = rpt_hit && !(state_q == ARM_UP && !s && db_done);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                rpt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= rpt_fire;
                release_q <= 1'b0;
                if (REPEAT_MASK[g] && tick_1ms && held)
                    rpt_q <= rpt_hit ? 12'(REPEAT_DLY_MS - REPEAT_MS) : rpt_inc;
                case (state_q)
                    IDLE: if (s) begin
                        state_q <= ARM_DN;
                        cnt_q   <= '0;
                    end
                    ARM_DN: if (!s) state_q <= IDLE;
                    else if (db_done) begin
                        state_q <= DOWN;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                        rpt_q   <= '0;
                    end else if (tick_1ms) cnt_q <= cnt_q + 8'd1;
                    DOWN: if (!s) begin
                        state_q <= ARM_UP;
                        cnt_q   <= '0;
                    end
                    ARM_UP: if (s) state_q <= DOWN;
                    else if (db_done) begin
                        state_q   <= IDLE;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else if (tick_1ms) cnt_q <= cnt_q + 8'd1;
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign btn_level[g]   = level_q;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = release_q;
    end
endmodule
